// File: rtl/decade_counter_pkg.sv
// Shared constants and the BCD step function for the clock display digit chain.
// The minutes/hours digit logic reuses next_digit.
package decade_counter_pkg;

   localparam int unsigned DIGIT_W = 4;
   localparam logic [DIGIT_W-1:0] BCD_MAX = 4'd9;

   // One up/down step of a single BCD digit, wrapping at 0 and BCD_MAX.
   function automatic logic [DIGIT_W-1:0] next_digit(
      input logic [DIGIT_W-1:0] q,
      input logic               inc
   );
      if (inc) begin
         return (q == BCD_MAX) ? '0 : q + 1'b1;
      end
      return (q == '0) ? BCD_MAX : q - 1'b1;
   endfunction

endpackage

// File: rtl/decade_counter.sv
// Single-digit up/down counter (0..MODULO-1) with saturating parallel load and
// combinational carry/borrow strobes that feed the next digit's i_ena.
module decade_counter
   import decade_counter_pkg::*;
#(
   parameter int MODULO = 10,
   parameter int WIDTH  = 4
) (
   input  logic             i_clk,
   input  logic             i_reset_n,
   input  logic             i_ena,
   input  logic             i_inc,
   input  logic             i_wr,
   input  logic [WIDTH-1:0] i_in,
   output logic             o_roll_high,
   output logic             o_roll_low,
   output logic [WIDTH-1:0] o_q
);

   localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MODULO - 1);

   logic [WIDTH-1:0] r_q;
   logic [WIDTH-1:0] w_step;
   logic [WIDTH-1:0] w_load;
   logic [WIDTH-1:0] w_next;
   logic             w_at_max;
   logic             w_at_zero;
   logic             w_tick;

   // The shared BCD step only applies to the default decimal digit.
   if (MODULO == 10 && WIDTH == int'(DIGIT_W)) begin : g_bcd
      always_comb begin
         w_step = next_digit(r_q, i_inc);
      end
   end else begin : g_generic
      always_comb begin
         w_step = r_q;
         if (i_inc) begin
            w_step = (r_q == MAX_Q) ? '0 : r_q + 1'b1;
         end else begin
            w_step = (r_q == '0) ? MAX_Q : r_q - 1'b1;
         end
      end
   end

   assign w_load    = (i_in > MAX_Q) ? MAX_Q : i_in;
   assign w_at_max  = (r_q == MAX_Q);
   assign w_at_zero = (r_q == '0);
   assign w_tick    = i_reset_n & ~i_wr & i_ena;

   always_comb begin
      w_next = r_q;
      if (i_wr) begin
         w_next = w_load;
      end else if (i_ena) begin
         w_next = w_step;
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         r_q <= '0;
      end else begin
         r_q <= w_next;
      end
   end

   assign o_roll_high = w_tick &  i_inc & w_at_max;
   assign o_roll_low  = w_tick & ~i_inc & w_at_zero;
   assign o_q         = r_q;

endmodule

// File: tb/tb_decade_counter.sv
// Scoreboard bench for decade_counter: the driver pushes per-cycle expectations
// from an arithmetic digit model, a monitor on the falling edge pops and compares.
module tb_decade_counter;

   localparam int MOD = 10;

   logic       i_clk = 1'b0;
   logic       i_reset_n = 1'b1;
   logic       i_ena = 1'b0;
   logic       i_inc = 1'b0;
   logic       i_wr = 1'b0;
   logic [3:0] i_in = 4'd0;
   logic       o_roll_high;
   logic       o_roll_low;
   logic [3:0] o_q;

   typedef struct {
      logic       chk_q;
      logic [3:0] q;
      logic       rh;
      logic       rl;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;
   int   mq = -1;

   decade_counter #(.MODULO(10), .WIDTH(4)) dut (
      .i_clk      (i_clk),
      .i_reset_n  (i_reset_n),
      .i_ena      (i_ena),
      .i_inc      (i_inc),
      .i_wr       (i_wr),
      .i_in       (i_in),
      .o_roll_high(o_roll_high),
      .o_roll_low (o_roll_low),
      .o_q        (o_q)
   );

   always #5 i_clk = ~i_clk;

   // One clock: drive inputs, record what the DUT should show this cycle,
   // then advance the model to the value after the coming edge.
   task automatic cyc(input logic rst_n, input logic ena, input logic inc,
                      input logic wr, input logic [3:0] din);
      exp_t e;
      @(posedge i_clk);
      #1;
      i_reset_n = rst_n;
      i_ena     = ena;
      i_inc     = inc;
      i_wr      = wr;
      i_in      = din;
      e.chk_q = (mq >= 0);
      e.q     = (mq >= 0) ? 4'(mq) : 4'd0;
      e.rh    = rst_n && !wr && ena && inc && (mq == MOD - 1);
      e.rl    = rst_n && !wr && ena && !inc && (mq == 0);
      sb.push_back(e);
      if (!rst_n) begin
         mq = 0;
      end else if (wr) begin
         mq = (int'(din) > MOD - 1) ? MOD - 1 : int'(din);
      end else if (ena && mq >= 0) begin
         mq = inc ? (mq + 1) % MOD : (mq + MOD - 1) % MOD;
      end
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge i_clk);
         if (sb.size() > 0) begin
            e = sb.pop_front();
            if (e.chk_q) begin
               checks++;
               if (o_q !== e.q) begin
                  errors++;
                  $display("FAIL q: got %0d expected %0d at %0t", o_q, e.q, $time);
               end
            end
            checks++;
            if (o_roll_high !== e.rh) begin
               errors++;
               $display("FAIL roll_high: got %b expected %b (q=%0d) at %0t",
                        o_roll_high, e.rh, o_q, $time);
            end
            checks++;
            if (o_roll_low !== e.rl) begin
               errors++;
               $display("FAIL roll_low: got %b expected %b (q=%0d) at %0t",
                        o_roll_low, e.rl, o_q, $time);
            end
            if (e.chk_q) begin
               checks++;
               if (!(o_q <= 4'(MOD - 1))) begin
                  errors++;
                  $display("FAIL range: got %0d expected <= %0d at %0t", o_q, MOD - 1, $time);
               end
            end
         end
      end
   end

   initial begin : driver
      // reset from an arbitrary loaded value, then idle
      cyc(1, 0, 0, 1, 4'd6);
      cyc(0, 0, 0, 0, 4'd0);
      cyc(0, 1, 1, 0, 4'd0);
      cyc(0, 0, 0, 0, 4'd0);
      repeat (3) cyc(1, 0, 0, 0, 4'd0);

      // count up, one tick every 5 clocks
      for (int i = 0; i < 12; i++) begin
         cyc(1, 1, 1, 0, 4'd0);
         repeat (4) cyc(1, 0, 1, 0, 4'd0);
      end

      // count down from 2
      cyc(1, 0, 0, 1, 4'd2);
      for (int i = 0; i < 12; i++) begin
         cyc(1, 1, 0, 0, 4'd0);
         repeat (4) cyc(1, 0, 0, 0, 4'd0);
      end

      // loads: direct, saturating, load beats a coincident tick at max
      cyc(1, 0, 1, 1, 4'h9);
      cyc(1, 0, 1, 0, 4'h0);
      cyc(1, 0, 1, 1, 4'hC);
      cyc(1, 1, 1, 1, 4'h3);
      cyc(1, 0, 1, 0, 4'h0);
      cyc(1, 0, 1, 1, 4'hF);
      cyc(1, 0, 1, 1, 4'hA);
      cyc(1, 0, 0, 1, 4'h0);
      cyc(1, 1, 0, 1, 4'h5);
      cyc(1, 0, 0, 0, 4'h0);

      // reset coincident with a tick at 7, then resume
      cyc(1, 0, 1, 1, 4'd7);
      cyc(0, 1, 1, 0, 4'd0);
      cyc(1, 0, 1, 0, 4'd0);
      cyc(1, 1, 1, 0, 4'd0);
      cyc(1, 0, 1, 0, 4'd0);

      // direction flip at 9 and at 0, and reset while sitting on a roll
      cyc(1, 0, 0, 1, 4'd9);
      cyc(1, 1, 0, 0, 4'd0);
      cyc(1, 1, 1, 0, 4'd0);
      cyc(1, 1, 1, 0, 4'd0);
      cyc(1, 1, 0, 0, 4'd0);
      cyc(1, 1, 1, 0, 4'd0);
      cyc(1, 1, 0, 0, 4'd0);
      cyc(1, 1, 0, 0, 4'd0);
      cyc(1, 0, 0, 1, 4'd9);
      cyc(0, 1, 1, 0, 4'd0);
      cyc(1, 0, 0, 0, 4'd0);

      // random traffic
      for (int i = 0; i < 600; i++) begin
         cyc(($urandom_range(0, 49) != 0), ($urandom_range(0, 9) < 4),
             1'($urandom), ($urandom_range(0, 9) == 0), 4'($urandom));
      end
      cyc(1, 0, 0, 0, 4'd0);

      for (int k = 0; k < 10 && sb.size() > 0; k++) @(negedge i_clk);
      #1;
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL drain: got %0d pending expected 0", sb.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/decade_counter.md
Name: decade_counter

Overview:
- Single-digit BCD up/down counter (0–9) for the clock display chain.
- Advances one step per enable tick; direction is selected by i_inc.
- Parallel-loadable via i_wr/i_in.
- Emits combinational carry (o_roll_high) and borrow (o_roll_low) strobes so digits cascade: a digit's roll output drives the next digit's i_ena.

Parameters:
- MODULO, 10, number of states; count range 0..MODULO-1.
- WIDTH, 4, bit width of i_in/o_q; must satisfy 2**WIDTH >= MODULO.

Ports:
- i_clk  in  1  system clock; all state changes on rising edge.
- i_reset_n  in  1  synchronous reset, active-low.
- i_ena  in  1  count-enable tick, single-cycle pulse from prescaler or lower digit.
- i_inc  in  1  direction: 1 = count up, 0 = count down.
- i_wr  in  1  synchronous load strobe.
- i_in  in  WIDTH  load value.
- o_roll_high  out  1  carry strobe: step taken from MODULO-1 up to 0.
- o_roll_low  out  1  borrow strobe: step taken from 0 down to MODULO-1.
- o_q  out  WIDTH  registered count value.

Behaviour:
- Interface (already decided): one clock, i_clk; reset i_reset_n is synchronous and active-low.
- Priority on each rising edge:
  - i_reset_n=0 → o_q<=0.
  - else i_wr=1 → o_q<=load value.
  - else i_ena=1 → step.
  - else hold.
- Load value: i_in if i_in <= MODULO-1; otherwise saturates to MODULO-1. So 4'hA..4'hF load 9.
- i_wr loads regardless of i_ena.
- Step up (i_inc=1): q==MODULO-1 → 0, else q+1.
- Step down (i_inc=0): q==0 → MODULO-1, else q-1.
- Latency: o_q updates one clock after the qualifying edge; no internal pipelining.
- Roll outputs are combinational from current o_q and inputs, asserted in the same cycle as the wrapping i_ena:
  - o_roll_high = i_reset_n & ~i_wr & i_ena & i_inc & (o_q==MODULO-1).
  - o_roll_low = i_reset_n & ~i_wr & i_ena & ~i_inc & (o_q==0).
  - Each is a one-cycle pulse per qualifying i_ena pulse.
  - At most one of the two is high in any cycle.
- Reset values: o_q=0; o_roll_high=0 and o_roll_low=0 while i_reset_n=0.
- i_inc may change between ticks; direction is sampled on the edge where i_ena=1.
- Reset mid-count: the next edge forces 0; no roll is emitted.
- i_wr coincident with i_ena: load wins, no step, rolls suppressed.
- o_q never leaves 0..MODULO-1 under any input sequence.
- No latches; all outputs defined from the first clock after reset.

Decomposition:
- Shared clock package holds:
  - BCD_MAX = 4'd9
  - DIGIT_W = 4
  - a next_digit(q, inc) step function, reused by the minutes/hours digit logic.
- No sub-module; single always-block register plus combinational next-state and roll logic.

Test Plan:
- Reset: hold i_reset_n=0 for ≥2 edges from arbitrary q → o_q=0, both rolls 0; release, no ena → o_q stays 0.
- Count up: i_inc=1, i_ena pulse every 5 clocks, 12 pulses from 0 → o_q sequence 1..9,0,1,2. o_roll_high high only during the ena cycle where o_q=9. o_roll_low never high.
- Count down: i_inc=0, 12 ena pulses from 2 → o_q 1,0,9,8,…,0. o_roll_low high only on ena cycles where o_q=0. o_roll_high never high.
- Load: i_wr=1, i_in=4'h9 without ena → o_q=9 next edge. i_in=4'hC → o_q=9 (saturate). i_in=4'h3 with i_ena=1, i_inc=1 → o_q=3, no step, no roll.
- Mid-operation reset: counting up at o_q=7, assert i_reset_n=0 coincident with an ena pulse → o_q=0 next edge, o_roll_high=0. Release, counting resumes at 1 on the next ena.
- Direction flip at boundary: o_q=9, i_inc=0 with ena → o_q=8, no roll. Then i_inc=1 twice → 9, then 0 with o_roll_high pulse.
